mmio_tx_port: RTL and testbench
===============================

# mmio_tx_port

Memory-mapped output peripheral on the CPU data bus. It is the responder for CPU stores to the output address. It accepts bytes written to `DATA_ADDR`, buffers them in a small FIFO, and transmits each one LSB-first as an asynchronous serial frame on `txd`. The CPU can poll a status register at `STATUS_ADDR` through the same bus. The block sits beside `Memory`; the top level muxes its read data in whenever `rdHit` is high.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; ≥2.
- `DATA_ADDR`, 8'hFF: TX data register address (write-only).
- `STATUS_ADDR`, 8'hFE: status register address; read returns status, write clears overflow.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `memAddress`  in  8  CPU data-bus address.
- `memIn`  in  8  CPU store data.
- `memWrEnable`  in  1  CPU store strobe; sampled on the rising edge.
- `rdData`  out  8  status byte while `rdHit` is high, else 8'h00; combinational.
- `rdHit`  out  1  high when `memAddress == STATUS_ADDR && !memWrEnable`; combinational.
- `txd`  out  1  serial line; idles high.
- `busy`  out  1  high when the FSM is not in IDLE.

## Operation
- Push: an edge with `memWrEnable && memAddress == DATA_ADDR` enqueues `memIn`.
  - If the FIFO is full at that edge, the byte is dropped and the sticky `overflow` bit is set.
  - A pop on the same edge does not make room for the push; full is evaluated before the pop.
- Clear: an edge with `memWrEnable && memAddress == STATUS_ADDR` clears `overflow`. If an overflow occurs on the same edge, the set wins.
- Status byte bits:
  - [0] full
  - [1] empty
  - [2] busy
  - [3] overflow
  - [7:4] always 0
- TX FSM states: IDLE → START → DATA → (PARITY) → STOP → IDLE.
  - IDLE: when the FIFO is non-empty, pop the head into the shift register on that edge, clear the bit counter, go to START.
  - START: `txd` = 0 for `CLKS_PER_BIT` cycles.
  - DATA: 8 bits, LSB first, each held `CLKS_PER_BIT` cycles; shift right at each bit boundary.
  - STOP: `txd` = 1 for `CLKS_PER_BIT` cycles, then IDLE.
- IDLE always lasts at least one cycle between frames.
- The baud counter counts 0 to `CLKS_PER_BIT-1` and wraps; the bit counter is 3 bits and wraps after bit 7.
- Reset values: FIFO empty, pointers 0, `overflow` = 0, FSM IDLE, `txd` = 1, `busy` = 0, counters 0.
- Reset mid-frame: `txd` returns high asynchronously and the partial frame is abandoned. The pending FIFO contents are lost.

## Timing
- Store at edge N: the byte is in the FIFO after N. Status read in cycle N+1 shows empty = 0.
- With the FSM in IDLE at edge N+1: pop at N+1; `txd` falls after N+1 and stays low through edge N+1+`CLKS_PER_BIT`.
- Frame length: (10, or 11 with parity) × `CLKS_PER_BIT` cycles.
- Back-to-back frames: one pop every frame length + 1 cycles.
- `busy` goes high on the pop edge and low on the edge entering IDLE.
- `rdData` and `rdHit` have zero-cycle latency from `memAddress` and reflect register state after the most recent edge.

## Configuration
- `MMIO_TX_PARITY_EN` defined: a PARITY state between DATA and STOP sends the even-parity bit (XOR of the 8 data bits) for `CLKS_PER_BIT` cycles. Frame length is 11 bits.
- Undefined: no PARITY state; 10-bit frame.

## Structure
- Package `mmio_pkg` holds:
  - `DATA_ADDR_DEFAULT` and `STATUS_ADDR_DEFAULT`.
  - Status bit index constants.
  - `tx_state_t` enum: IDLE, START, DATA, PARITY, STOP.
- Sub-module `byte_fifo`: parameterised synchronous FIFO.
  - Push/pop/full/empty interface, `DEPTH`-deep storage.
  - Pointers one bit wider than the address to distinguish full from empty.
  - Same `clk` and `rst` as the parent.
- The top holds the bus decode, the status register and the TX FSM.

## Test plan
All scenarios use `CLKS_PER_BIT` = 4 and `DEPTH` = 4.
- Reset: pulse `rst` low mid-run → `txd` = 1, `busy` = 0, status read at 8'hFE = 8'h02.
- Single byte: store 8'h55 to 8'hFF at edge N → `txd` low for cycles N+1..N+4, then data 1,0,1,0,1,0,1,0 each 4 cycles, then high 4 cycles; `busy` falls at N+41.
- Overflow: store 6 bytes on consecutive edges → first popped, next 4 fill the FIFO, 6th dropped. Status bit 3 = 1 and bit 0 = 1. Exactly 5 frames are transmitted in order.
- Clear: store any value to 8'hFE after the overflow → the next status read has bit 3 = 0. FIFO contents are unaffected.
- Reset mid-frame: assert `rst` during the DATA state of a queued stream → `txd` high immediately; after release, status = 8'h02 and no further frames are sent.
- Parity (`MMIO_TX_PARITY_EN`): store 8'h07 → the parity bit after bit 7 is 1; frame is 44 cycles.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared constants and types for the MMIO serial transmit port.
package mmio_pkg;

  localparam logic [7:0] DATA_ADDR_DEFAULT   = 8'hFF;
  localparam logic [7:0] STATUS_ADDR_DEFAULT = 8'hFE;

  // Bit positions inside the status byte; bits [7:4] read as zero
  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

endpackage

// File: rtl/mmio_tx_port_if.sv
// CPU data-bus signals seen by the MMIO transmit port.
interface mmio_tx_port_if;
  logic [7:0] memAddress;
  logic [7:0] memIn;
  logic       memWrEnable;
  logic [7:0] rdData;
  logic       rdHit;

  modport master (output memAddress, memIn, memWrEnable, input rdData, rdHit);
  modport slave  (input memAddress, memIn, memWrEnable, output rdData, rdHit);
endinterface

// File: rtl/byte_fifo.sv
// Synchronous FIFO; pointers carry one extra wrap bit to tell full from empty.
// A push while full is ignored even if a pop happens on the same edge.
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]               wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DEPTH-1:0][W-1:0]   mem_q, mem_d;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rd_data = mem_q[rptr_q[AW-1:0]];

  // Next-state: write at the tail, advance the head on pop
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push && !full) begin
      mem_d[wptr_q[AW-1:0]] = wr_data;
      wptr_d                = wptr_q + 1'b1;
    end
    if (pop && !empty) rptr_d = rptr_q + 1'b1;
  end

  // Storage and pointer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end
endmodule

// File: rtl/mmio_tx_port.sv
// Memory-mapped serial transmitter: bus decode, status register, FIFO and
// LSB-first TX FSM. Define MMIO_TX_PARITY_EN to add an even-parity bit.
module mmio_tx_port
  import mmio_pkg::*;
#(
  parameter int         DEPTH        = 4,
  parameter int         CLKS_PER_BIT = 16,
  parameter logic [7:0] DATA_ADDR    = DATA_ADDR_DEFAULT,
  parameter logic [7:0] STATUS_ADDR  = STATUS_ADDR_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  mmio_tx_port_if.slave  bus,
  output logic           txd,
  output logic           busy
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  logic       push, clr, pop;
  logic       fifo_full, fifo_empty;
  logic [7:0] fifo_rd;
  logic [7:0] status;

  tx_state_t     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          txd_q, txd_d, busy_q, busy_d, ovf_q, ovf_d;
`ifdef MMIO_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  byte_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (bus.memIn),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Bus decode and sticky overflow; a same-edge overflow beats the clear
  always_comb begin
    push  = bus.memWrEnable && (bus.memAddress == DATA_ADDR);
    clr   = bus.memWrEnable && (bus.memAddress == STATUS_ADDR);
    ovf_d = ovf_q;
    if (push && fifo_full) ovf_d = 1'b1;
    else if (clr)          ovf_d = 1'b0;
  end

  // Status byte and zero-latency read mux
  always_comb begin
    status           = '0;
    status[ST_FULL]  = fifo_full;
    status[ST_EMPTY] = fifo_empty;
    status[ST_BUSY]  = busy_q;
    status[ST_OVF]   = ovf_q;
  end
  assign bus.rdHit  = (bus.memAddress == STATUS_ADDR) && !bus.memWrEnable;
  assign bus.rdData = bus.rdHit ? status : 8'h00;
  assign txd        = txd_q;
  assign busy       = busy_q;

  // TX FSM next-state; txd is registered so it changes on the bit boundary
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    pop     = 1'b0;
`ifdef MMIO_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != IDLE) baud_d = (baud_q == BAUD_MAX) ? '0 : baud_q + 1'b1;
    case (state_q)
      IDLE: if (!fifo_empty) begin
        pop     = 1'b1;
        sh_d    = fifo_rd;
        bit_d   = '0;
        baud_d  = '0;
        txd_d   = 1'b0;
        busy_d  = 1'b1;
        state_d = START;
`ifdef MMIO_TX_PARITY_EN
        par_d   = ^fifo_rd;
`endif
      end
      START: if (baud_q == BAUD_MAX) begin
        txd_d   = sh_q[0];
        state_d = DATA;
      end
      DATA: if (baud_q == BAUD_MAX) begin
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
`ifdef MMIO_TX_PARITY_EN
          txd_d   = par_q;
          state_d = PARITY;
`else
          txd_d   = 1'b1;
          state_d = STOP;
`endif
        end else begin
          sh_d  = sh_q >> 1;
          txd_d = sh_q[1];
        end
      end
`ifdef MMIO_TX_PARITY_EN
      PARITY: if (baud_q == BAUD_MAX) begin
        txd_d   = 1'b1;
        state_d = STOP;
      end
`endif
      STOP: if (baud_q == BAUD_MAX) begin
        txd_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, datapath and status registers; reset drives txd high immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef MMIO_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
`ifdef MMIO_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end
endmodule

// File: tb/tb_mmio_tx_port.sv
// Bench for mmio_tx_port: scoreboard of expected bytes checked by a serial
// frame decoder, plus cycle-exact checks on a single frame and the status byte.
module tb_mmio_tx_port;
  localparam int C = 4;
`ifdef MMIO_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic clk = 1'b0;
  logic rst;
  logic txd, busy;
  mmio_tx_port_if bus();

  mmio_tx_port #(.DEPTH(4), .CLKS_PER_BIT(C), .DATA_ADDR(8'hFF), .STATUS_ADDR(8'hFE)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .txd  (txd),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int         n_chk  = 0;
  int         n_fail = 0;
  int         frames = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_n(input int n, output bit ok);
    ok = 1'b1;
    repeat (n) begin
      @(negedge clk);
      if (!rst) ok = 1'b0;
    end
  endtask

  // Decode one frame starting at the first low sample; abandon it on reset
  task automatic decode_frame();
    bit         ok, have;
    logic [7:0] b, e;
    b = '0;
    e = '0;
    have = (exp_q.size() > 0);
    if (have) e = exp_q.pop_front();
    wait_n(C/2, ok); if (!ok) return;
    chk("start_bit", 32'(txd), 32'd0);
    for (int i = 0; i < 8; i++) begin
      wait_n(C, ok); if (!ok) return;
      b[i] = txd;
    end
`ifdef MMIO_TX_PARITY_EN
    wait_n(C, ok); if (!ok) return;
    chk("parity_bit", 32'(txd), 32'(^e));
`endif
    wait_n(C, ok); if (!ok) return;
    chk("stop_bit", 32'(txd), 32'd1);
    chk("sb_nonempty", 32'(have), 32'd1);
    chk("frame_data", 32'(b), 32'(e));
    frames++;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && txd === 1'b0) decode_frame();
    end
  end

  task automatic rd_status(output logic [7:0] s);
    bus.memAddress  = 8'hFE;
    bus.memWrEnable = 1'b0;
    #1 s = bus.rdData;
  endtask

  // One store edge; the expected byte is queued only if the FIFO will take it
  task automatic store(input logic [7:0] a, input logic [7:0] d, input bit accepted);
    @(negedge clk);
    bus.memAddress  = a;
    bus.memIn       = d;
    bus.memWrEnable = 1'b1;
    if (accepted) exp_q.push_back(d);
    @(negedge clk);
    bus.memWrEnable = 1'b0;
    bus.memAddress  = 8'hFE;
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n < max), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [7:0]  s;
    logic [10:0] fr;
    logic [7:0]  d;
    int          f0, lows;

    bus.memAddress  = 8'hFE;
    bus.memIn       = 8'h00;
    bus.memWrEnable = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    rd_status(s);
    chk("rst_status", 32'(s), 32'h02);
    chk("rst_rdhit", 32'(bus.rdHit), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Non-status address reads as zero with no hit
    @(negedge clk);
    bus.memAddress = 8'hFF;
    #1;
    chk("miss_rdhit", 32'(bus.rdHit), 32'd0);
    chk("miss_rddata", 32'(bus.rdData), 32'd0);

    // Single byte: exact waveform and busy timing
`ifdef MMIO_TX_PARITY_EN
    d = 8'h07;
    fr = {1'b1, ^d, d, 1'b0};
`else
    d = 8'h55;
    fr = {1'b0, 1'b1, d, 1'b0};
`endif
    store(8'hFF, d, 1'b1);
    rd_status(s);
    chk("post_store_status", 32'(s), 32'h00);
    chk("pre_pop_txd", 32'(txd), 32'd1);
    for (int k = 0; k < FB*C; k++) begin
      @(negedge clk);
      chk($sformatf("wave_c%0d", k), 32'(txd), 32'(fr[k/C]));
      if (k == 0 || k == FB*C-1) chk("busy_in_frame", 32'(busy), 32'd1);
    end
    @(negedge clk);
    chk("busy_fall", 32'(busy), 32'd0);
    chk("txd_idle", 32'(txd), 32'd1);
    wait_idle(50);
    chk("single_frames", 32'(frames), 32'd1);

    // Overflow: six stores on consecutive edges, last one dropped
    f0 = frames;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.memAddress  = 8'hFF;
      bus.memIn       = 8'hA0 + 8'(i);
      bus.memWrEnable = 1'b1;
      if (i < 5) exp_q.push_back(8'hA0 + 8'(i));
    end
    @(negedge clk);
    rd_status(s);
    chk("ovf_status", 32'(s), 32'h0D);

    // Clear the overflow while the FIFO stays full
    store(8'hFE, 8'h3C, 1'b0);
    rd_status(s);
    chk("clr_status", 32'(s), 32'h05);
    wait_idle(FB*C*6 + 50);
    chk("ovf_frames", 32'(frames - f0), 32'd5);
    rd_status(s);
    chk("drained_status", 32'(s), 32'h02);

    // Reset in the middle of a queued stream
    store(8'hFF, 8'h81, 1'b1);
    store(8'hFF, 8'h42, 1'b1);
    store(8'hFF, 8'h24, 1'b1);
    repeat (8) @(negedge clk);
    f0 = frames;
    #2 rst = 1'b0;
    #1;
    chk("midrst_txd", 32'(txd), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    rd_status(s);
    chk("midrst_status", 32'(s), 32'h02);
    lows = 0;
    repeat (FB*C*2) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) lows++;
    end
    chk("midrst_quiet", 32'(lows), 32'd0);
    chk("midrst_frames", 32'(frames - f0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
